// File: rtl/traffic_disp_pkg.sv
// Shared constants for the traffic display scanner: segment patterns, the blank code
// and the digit-slot index type.
package traffic_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef logic [1:0] slot_idx_t;

    localparam slot_idx_t SLOT_A_L = 2'd0;
    localparam slot_idx_t SLOT_A_H = 2'd1;
    localparam slot_idx_t SLOT_B_L = 2'd2;
    localparam slot_idx_t SLOT_B_H = 2'd3;

endpackage

// File: rtl/traffic_display_scan_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes A..E show a dash, F is blank.
module bcd_to_seg
    import traffic_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            BCD_BLANK: seg = SEG_BLANK;
            default:   seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/traffic_display_scan.sv
// Multiplexed 7-segment scanner for the four countdown digits with per-frame snapshot.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank a tens digit of 0.
module traffic_display_scan
    import traffic_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
)
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [3:0] A_Time_L,
    input  logic [3:0] A_Time_H,
    input  logic [3:0] B_Time_L,
    input  logic [3:0] B_Time_H,
    input  logic       A_Light,
    input  logic       B_Light,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] Dig_En,
    output logic       Frame_Start
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] prescaler;
    slot_idx_t   index;
    logic [3:0]  snap_a_l, snap_a_h, snap_b_l, snap_b_h;
    logic        snap_a_light, snap_b_light;

    logic        take;
    logic        last;
    logic [3:0]  next_a_l, next_a_h, next_b_l, next_b_h;
    logic        next_a_light, next_b_light;
    logic [3:0]  sel_code;
    logic        sel_dp;
    logic [6:0]  dec_seg;
    logic [6:0]  shown_seg;

    assign take = (prescaler == 16'd0) && (index == SLOT_A_L);
    assign last = (prescaler == PRESC_LAST);

    // The snapshot cycle forwards the fresh inputs so slot 0 shows them one cycle later.
    always_comb begin
        next_a_l     = take ? A_Time_L : snap_a_l;
        next_a_h     = take ? A_Time_H : snap_a_h;
        next_b_l     = take ? B_Time_L : snap_b_l;
        next_b_h     = take ? B_Time_H : snap_b_h;
        next_a_light = take ? A_Light  : snap_a_light;
        next_b_light = take ? B_Light  : snap_b_light;
    end

    always_comb begin
        sel_code = next_a_l;
        sel_dp   = 1'b0;
        case (index)
            SLOT_A_L: sel_code = next_a_l;
            SLOT_A_H: begin
                sel_code = next_a_h;
                sel_dp   = next_a_light;
            end
            SLOT_B_L: sel_code = next_b_l;
            SLOT_B_H: begin
                sel_code = next_b_h;
                sel_dp   = next_b_light;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .code (sel_code),
        .seg  (dec_seg)
    );

    // Odd slots carry the tens digits.
    always_comb begin
        shown_seg = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (index[0] && (sel_code == 4'd0)) begin
            shown_seg = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            prescaler    <= 16'd0;
            index        <= SLOT_A_L;
            snap_a_l     <= BCD_BLANK;
            snap_a_h     <= BCD_BLANK;
            snap_b_l     <= BCD_BLANK;
            snap_b_h     <= BCD_BLANK;
            snap_a_light <= 1'b0;
            snap_b_light <= 1'b0;
            Seg          <= SEG_BLANK;
            Dp           <= 1'b0;
            Dig_En       <= 4'b0000;
            Frame_Start  <= 1'b0;
        end else begin
            prescaler    <= last ? 16'd0 : prescaler + 16'd1;
            if (last) begin
                index <= index + 2'd1;
            end
            snap_a_l     <= next_a_l;
            snap_a_h     <= next_a_h;
            snap_b_l     <= next_b_l;
            snap_b_h     <= next_b_h;
            snap_a_light <= next_a_light;
            snap_b_light <= next_b_light;
            // The final prescaler count of each slot goes dark to avoid ghosting on the switch.
            Seg          <= last ? SEG_BLANK : shown_seg;
            Dig_En       <= last ? 4'b0000 : (4'b0001 << index);
            Dp           <= sel_dp;
            Frame_Start  <= take;
        end
    end

endmodule

// File: tb/tb_traffic_display_scan.sv
// Randomized bench for traffic_display_scan at SCAN_DIV=4 and SCAN_DIV=2 against a
// frame-position model of the scanner.
module tb_traffic_display_scan;

    localparam logic [6:0] DIGIT_SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_l, a_h, b_l, b_h;
    logic       a_light, b_light;

    logic [6:0] seg4, seg2;
    logic       dp4, dp2, fs4, fs2;
    logic [3:0] dig4, dig2;

    logic [12:0] act_out [2];
    logic [12:0] exp_out [2];
    logic [3:0]  snap [2][4];
    logic        snap_la [2];
    logic        snap_lb [2];
    int          cyc [2];

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_display_scan #(.SCAN_DIV(4)) u_dut4 (
        .Clk(clk), .Rst_n(rst_n),
        .A_Time_L(a_l), .A_Time_H(a_h), .B_Time_L(b_l), .B_Time_H(b_h),
        .A_Light(a_light), .B_Light(b_light),
        .Seg(seg4), .Dp(dp4), .Dig_En(dig4), .Frame_Start(fs4)
    );

    traffic_display_scan #(.SCAN_DIV(2)) u_dut2 (
        .Clk(clk), .Rst_n(rst_n),
        .A_Time_L(a_l), .A_Time_H(a_h), .B_Time_L(b_l), .B_Time_H(b_h),
        .A_Light(a_light), .B_Light(b_light),
        .Seg(seg2), .Dp(dp2), .Dig_En(dig2), .Frame_Start(fs2)
    );

    assign act_out[0] = {seg4, dp4, dig4, fs4};
    assign act_out[1] = {seg2, dp2, dig2, fs2};

    function automatic logic [6:0] ref_decode(input logic [3:0] code, input logic [1:0] slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot[0] && code == 4'd0) return 7'h00;
`else
        if (slot == 2'd3 && code == 4'd15) return 7'h00;
`endif
        if (code <= 4'd9) return DIGIT_SEGS[code];
        if (code == 4'hF) return 7'h00;
        return 7'h40;
    endfunction

    // Model: position in the frame is the count of active edges since reset, mod 4*N.
    always @(posedge clk) begin : model
        int nd, q;
        logic [1:0] slot;
        logic dark, dp;
        for (int k = 0; k < 2; k++) begin
            nd = (k == 0) ? 4 : 2;
            if (!rst_n) begin
                cyc[k] = 0;
                for (int d = 0; d < 4; d++) snap[k][d] = 4'hF;
                snap_la[k] = 1'b0;
                snap_lb[k] = 1'b0;
                exp_out[k] = 13'd0;
            end else begin
                q = cyc[k] % (4 * nd);
                if (q == 0) begin
                    snap[k][0] = a_l;
                    snap[k][1] = a_h;
                    snap[k][2] = b_l;
                    snap[k][3] = b_h;
                    snap_la[k] = a_light;
                    snap_lb[k] = b_light;
                end
                slot = 2'(q / nd);
                dark = (q % nd) == (nd - 1);
                dp   = (slot == 2'd1) ? snap_la[k] : (slot == 2'd3) ? snap_lb[k] : 1'b0;
                exp_out[k] = {dark ? 7'h00 : ref_decode(snap[k][slot], slot), dp,
                              dark ? 4'b0000 : (4'b0001 << slot), q == 0};
                cyc[k]++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        a_l = 4'h2; a_h = 4'h1; b_l = 4'h9; b_h = 4'h0;
        a_light = 1'b1; b_light = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            asserts++;
            if (act_out[k] !== 13'd0) begin
                failures++;
                $display("[TB] FAIL reset_state dut%0d: got %h expected %h", k, act_out[k], 13'd0);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [12:0] want;
        for (int j = 1; j <= 48; j++) begin
            @(negedge clk);
            if (j == 1 || j == 6 || j == 10 || j == 13) begin
                case (j)
                    1:  want = {7'h5B, 1'b0, 4'b0001, 1'b1};
                    6:  want = {7'h06, 1'b1, 4'b0010, 1'b0};
                    10: want = {7'h6F, 1'b0, 4'b0100, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
                    default: want = {7'h00, 1'b0, 4'b1000, 1'b0};
`else
                    default: want = {7'h3F, 1'b0, 4'b1000, 1'b0};
`endif
                endcase
                asserts++;
                if (act_out[0] !== want) begin
                    failures++;
                    $display("[TB] FAIL basic_plan cycle %0d: got %h expected %h", j, act_out[0], want);
                end
            end
            for (int k = 0; k < 2; k++) begin
                asserts++;
                if (act_out[k] !== exp_out[k]) begin
                    failures++;
                    $display("[TB] FAIL basic dut%0d cycle %0d: got %h expected %h", k, j, act_out[k], exp_out[k]);
                end
            end
        end
    endtask

    task automatic test_snapshot_hold();
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (exp_out[0][0] !== 1'b1 && budget < 40);
        asserts++;
        if (fs4 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_frame_start: got %b expected 1 within %0d cycles", fs4, budget);
        end
        a_l = 4'h7;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                asserts++;
                if (act_out[k] !== exp_out[k]) begin
                    failures++;
                    $display("[TB] FAIL snapshot_hold dut%0d cycle %0d: got %h expected %h", k, j, act_out[k], exp_out[k]);
                end
            end
        end
    endtask

    task automatic test_patterns(input logic [3:0] al, input logic [3:0] ah, input logic [3:0] bl,
                                 input logic [3:0] bh, input logic la, input logic lb);
        @(negedge clk);
        a_l = al; a_h = ah; b_l = bl; b_h = bh; a_light = la; b_light = lb;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                asserts++;
                if (act_out[k] !== exp_out[k]) begin
                    failures++;
                    $display("[TB] FAIL pattern %h%h%h%h dut%0d cycle %0d: got %h expected %h", al, ah, bl, bh, k, j, act_out[k], exp_out[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                asserts++;
                if (act_out[k] !== exp_out[k]) begin
                    failures++;
                    $display("[TB] FAIL random dut%0d cycle %0d: got %h expected %h", k, j, act_out[k], exp_out[k]);
                end
            end
            a_l = 4'($urandom_range(0, 15));
            a_h = 4'($urandom_range(0, 15));
            b_l = 4'($urandom_range(0, 15));
            b_h = 4'($urandom_range(0, 15));
            a_light = 1'($urandom_range(0, 1));
            b_light = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (dig4 !== 4'b0100 && budget < 40);
        asserts++;
        if (dig4 !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL mid_reset_slot2_wait: got %b expected 0100", dig4);
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            asserts++;
            if (act_out[k] !== 13'd0) begin
                failures++;
                $display("[TB] FAIL mid_reset_zero dut%0d: got %h expected %h", k, act_out[k], 13'd0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        asserts++;
        if ({fs4, fs2, dig4, dig2} !== {1'b1, 1'b1, 4'b0001, 4'b0001}) begin
            failures++;
            $display("[TB] FAIL mid_reset_restart: got fs %b%b dig %b/%b expected fs 11 dig 0001/0001", fs4, fs2, dig4, dig2);
        end
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                asserts++;
                if (act_out[k] !== exp_out[k]) begin
                    failures++;
                    $display("[TB] FAIL mid_reset dut%0d cycle %0d: got %h expected %h", k, j, act_out[k], exp_out[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_l = 4'hF; a_h = 4'hF; b_l = 4'hF; b_h = 4'hF;
        a_light = 1'b0; b_light = 1'b0;
        test_reset();
        test_basic();
        test_snapshot_hold();
        test_patterns(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        test_patterns(4'h3, 4'h0, 4'hC, 4'h5, 1'b0, 1'b1);
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
